pixel_buffer_ctrl: RTL and testbench

PIXEL_BUFFER_CTRL -- requirements
Module: pixel_buffer_ctrl

---
 rtl/pixel_buffer_ctrl_pkg.sv | 24 ++
 rtl/mod_counter.sv | 34 +++
 rtl/pixel_buffer_ctrl.sv | 97 +++++++++
 tb/tb_pixel_buffer_ctrl.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/pixel_buffer_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pixel_buffer_ctrl_pkg
// Shared definitions for the sliding-window line-buffer controller.
//   LOG2 : ceiling log2 with a minimum result of 1, used to size the
//          address and counter fields
//   L, R : left and right tap indices of one window row
// -----------------------------------------------------------------------------
package pixel_buffer_ctrl_pkg;

    localparam int L = 0;
    localparam int R = 1;

    function automatic int LOG2(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/mod_counter.sv
// -----------------------------------------------------------------------------
// mod_counter
// Modulo-MOD up-counter that advances only when enabled.
//   clk   : clock, rising edge
//   reset : asynchronous active-high clear to 0
//   en    : advance by one this cycle
//   count : current value, 0..MOD-1
//   wrap  : count sits at MOD-1, so the next advance returns to 0
// -----------------------------------------------------------------------------
module mod_counter #(
    parameter int MOD   = 2,
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    output logic [WIDTH-1:0] count,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(MOD - 1);

    // Terminal count, not gated by en; callers qualify it with their own enable.
    assign wrap = (count == LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (en) begin
            count <= wrap ? '0 : count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/pixel_buffer_ctrl.sv
// -----------------------------------------------------------------------------
// pixel_buffer_ctrl
// Control for a FILTER_SIZE x FILTER_SIZE sliding window over a square
// IMAGE_SIZE x IMAGE_SIZE image streamed in raster order through an
// external synchronous-read line buffer. The block holds no pixel data.
//   clk            : clock, rising edge
//   reset          : asynchronous active-high reset
//   in_valid       : upstream pixel valid
//   in_ready       : pixel accepted this cycle (when in_valid is high)
//   out_ready      : downstream accepts the window
//   out_valid      : the window at the line-buffer output is complete
//   buffer_clk_en  : advance strobe for the line buffer and window registers
//   buffer_wr_addr : line-buffer write address
//   buffer_rd_addr : line-buffer read address
//   out_last       : qualifies the final window of a frame
//   frame_done     : one-cycle pulse after the last pixel of a frame
// -----------------------------------------------------------------------------
module pixel_buffer_ctrl
    import pixel_buffer_ctrl_pkg::*;
#(
    parameter  int FILTER_SIZE = 3,
    parameter  int IMAGE_SIZE  = 28,
    localparam int AW          = LOG2(IMAGE_SIZE)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          out_ready,
    output logic          out_valid,
    output logic          buffer_clk_en,
    output logic [AW-1:0] buffer_wr_addr,
    output logic [AW-1:0] buffer_rd_addr,
    output logic          out_last,
    output logic          frame_done
);

    // The FILTER_SIZE-1 window registers supply the rest of the row delay.
    localparam int DEPTH = IMAGE_SIZE - (FILTER_SIZE - 1);

    localparam logic [AW-1:0] EDGE = AW'(FILTER_SIZE - 1);

    logic          step;
    logic          win_pos;
    logic          col_wrap;
    logic          row_wrap;
    logic          ptr_wrap;
    logic [AW-1:0] col;
    logic [AW-1:0] row;
    logic [AW-1:0] ptr;

    mod_counter #(.MOD(IMAGE_SIZE), .WIDTH(AW)) u_col (
        .clk   (clk),
        .reset (reset),
        .en    (step),
        .count (col),
        .wrap  (col_wrap)
    );

    mod_counter #(.MOD(IMAGE_SIZE), .WIDTH(AW)) u_row (
        .clk   (clk),
        .reset (reset),
        .en    (step & col_wrap),
        .count (row),
        .wrap  (row_wrap)
    );

    // Free-running across frames: the line buffer is a circular delay line.
    mod_counter #(.MOD(DEPTH), .WIDTH(AW)) u_ptr (
        .clk   (clk),
        .reset (reset),
        .en    (step),
        .count (ptr),
        .wrap  (ptr_wrap)
    );

    // Only pixels that complete a window can be back-pressured.
    assign win_pos        = (row >= EDGE) && (col >= EDGE);
    assign in_ready       = out_ready | ~win_pos;
    assign step           = in_valid & in_ready;
    assign buffer_clk_en  = step;
    assign out_valid      = in_valid & win_pos;
    assign out_last       = out_valid & row_wrap & col_wrap;
    assign buffer_wr_addr = ptr;
    // Read one slot ahead so the synchronous read lands on the oldest entry.
    assign buffer_rd_addr = ptr_wrap ? '0 : ptr + AW'(1);

    // Registered end-of-frame pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_done <= 1'b0;
        end else begin
            frame_done <= step & row_wrap & col_wrap;
        end
    end

endmodule

// File: tb/tb_pixel_buffer_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pixel_buffer_ctrl
// Directed bench for pixel_buffer_ctrl with FILTER_SIZE=3, IMAGE_SIZE=5
// (DEPTH=3). Window positions come from a hand-written index table.
// -----------------------------------------------------------------------------
module tb_pixel_buffer_ctrl;

    localparam int FS = 3;
    localparam int IS = 5;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          out_ready = 1'b1;
    logic          out_valid;
    logic          buffer_clk_en;
    logic [AW-1:0] buffer_wr_addr;
    logic [AW-1:0] buffer_rd_addr;
    logic          out_last;
    logic          frame_done;

    int n_chk  = 0;
    int n_pass = 0;

    // Bench-side position tracking
    int cur_idx = 0;
    int cur_ptr = 0;
    int exp_fd  = 0;
    int dut_win = 0;

    // Raster indices (row*5+col) whose row>=2 and col>=2
    int win_idx [9] = '{12, 13, 14, 17, 18, 19, 22, 23, 24};

    always #5 clk = ~clk;

    pixel_buffer_ctrl #(.FILTER_SIZE(FS), .IMAGE_SIZE(IS)) dut (
        .clk            (clk),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .out_ready      (out_ready),
        .out_valid      (out_valid),
        .buffer_clk_en  (buffer_clk_en),
        .buffer_wr_addr (buffer_wr_addr),
        .buffer_rd_addr (buffer_rd_addr),
        .out_last       (out_last),
        .frame_done     (frame_done)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int is_win(input int idx);
        for (int i = 0; i < 9; i++) begin
            if (win_idx[i] == idx) return 1;
        end
        return 0;
    endfunction

    // Called at posedge+1: drives one cycle, checks mid-cycle, then advances
    // the bench position if a step was expected.
    task automatic drive(input logic v, input logic rdy);
        int wp;
        int st;
        in_valid  = v;
        out_ready = rdy;
        #4;
        wp = is_win(cur_idx);
        st = (v && (rdy || wp == 0)) ? 1 : 0;
        check("in_ready",   in_ready,       (rdy || wp == 0) ? 1 : 0);
        check("clk_en",     buffer_clk_en,  st);
        check("wr_addr",    buffer_wr_addr, cur_ptr);
        check("rd_addr",    buffer_rd_addr, (cur_ptr + 1) % 3);
        check("out_valid",  out_valid,      (v && wp != 0) ? 1 : 0);
        check("out_last",   out_last,       (v && wp != 0 && cur_idx == 24) ? 1 : 0);
        check("frame_done", frame_done,     exp_fd);
        if (out_valid && out_ready) dut_win++;
        @(posedge clk);
        #1;
        exp_fd = (st != 0 && cur_idx == 24) ? 1 : 0;
        if (st != 0) begin
            cur_idx = (cur_idx + 1) % 25;
            cur_ptr = (cur_ptr + 1) % 3;
        end
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        reset     = 1'b1;
        #2;
        check("rst_wr_addr",    buffer_wr_addr, 0);
        check("rst_rd_addr",    buffer_rd_addr, 1);
        check("rst_frame_done", frame_done,     0);
        check("rst_out_valid",  out_valid,      0);
        check("rst_in_ready",   in_ready,       1);
        @(posedge clk);
        #1;
        reset   = 1'b0;
        cur_idx = 0;
        cur_ptr = 0;
        exp_fd  = 0;
    endtask

    task automatic frame_full(input string tag);
        dut_win = 0;
        for (int k = 0; k < 25; k++) drive(1'b1, 1'b1);
        check(tag, dut_win, 9);
    endtask

    initial begin
        @(posedge clk);
        #1;
        do_reset();

        // Two back-to-back frames, full throughput
        frame_full("windows_frame1");
        check("fd_model_after_f1", exp_fd, 1);
        frame_full("windows_frame2");

        // Back-pressure held on pixel 13 (index 12)
        dut_win = 0;
        for (int k = 0; k < 12; k++) drive(1'b1, 1'b1);
        for (int k = 0; k < 4; k++) drive(1'b1, 1'b0);
        check("stall_idx_held", cur_idx, 12);
        for (int k = 0; k < 13; k++) drive(1'b1, 1'b1);
        check("windows_stall", dut_win, 9);

        // in_valid toggling, from reset
        do_reset();
        dut_win = 0;
        for (int k = 0; k < 25; k++) begin
            drive(1'b1, 1'b1);
            drive(1'b0, 1'b1);
        end
        check("windows_toggle", dut_win, 9);

        // out_ready low over pixels 1-10 never stalls
        dut_win = 0;
        for (int k = 0; k < 10; k++) drive(1'b1, 1'b0);
        check("no_stall_idx", cur_idx, 10);
        for (int k = 0; k < 15; k++) drive(1'b1, 1'b1);
        check("windows_early_low", dut_win, 9);

        // Mid-frame reset after pixel 17
        do_reset();
        for (int k = 0; k < 17; k++) drive(1'b1, 1'b1);
        in_valid = 1'b1;
        reset    = 1'b1;
        #2;
        check("mid_rst_wr_addr",  buffer_wr_addr, 0);
        check("mid_rst_rd_addr",  buffer_rd_addr, 1);
        check("mid_rst_out_valid", out_valid,     0);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        reset   = 1'b0;
        cur_idx = 0;
        cur_ptr = 0;
        exp_fd  = 0;
        frame_full("windows_after_rst");

        // frame_done pulse then drop
        drive(1'b0, 1'b1);
        drive(1'b0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
